clk_ratio_meter: RTL and testbench
==================================

// Module: clk_ratio_meter
// PURPOSE
//  Measure a divided clock (e.g. the output of clk_divider) against the system
//  clock and recover the integer ratio. Reports the period and high time in
//  i_clk cycles, a per-period valid strobe, a lock flag and a stall timeout.
//  Used in BIST/self-check of divider outputs; the divided clock is treated as
//  data (no logic is clocked by it).
// PARAMETERS
//  MAX_DIV   64  largest measurable period in i_clk cycles (>=2); longer => timeout
//  LOCK_CNT  4   consecutive equal periods required to assert o_locked (>=1)
//  CW        localparam = $clog2(MAX_DIV+1), width of period/high counters
// PORTS
//  i_clk      in   1   system clock; all logic on rising edge
//  i_rst_n    in   1   asynchronous reset, active low
//  i_div_clk  in   1   divided clock under measurement, asynchronous to i_clk
//  o_period   out  CW  last measured period, rising edge to rising edge
//  o_high     out  CW  i_clk cycles i_div_clk was high within that period
//  o_valid    out  1   1-cycle strobe: o_period/o_high just updated
//  o_locked   out  1   LOCK_CNT consecutive equal periods observed
//  o_timeout  out  1   no rising edge for more than MAX_DIV cycles
// BEHAVIOUR
//  - Reset: all outputs 0, sync/edge flops 0, counters 0, match count 0, FSM=IDLE.
//  - Input path: 2-flop synchroniser (s1, s2) plus delay flop s3.
//    rise = s2 & ~s3. rise is seen 3 i_clk edges after i_div_clk rises.
//  - Counters on each rise: cnt<=1, hi<=1. Otherwise: cnt<=cnt+1, hi<=hi+s2.
//    At a rise, cnt = cycles since the previous rise and hi = high cycles.
//  - FSM IDLE: waits for the first rise, then loads counters and goes to MEASURE.
//    No o_valid on this first rise.
//  - FSM MEASURE on rise: o_period<=cnt, o_high<=hi, o_valid=1 for one cycle.
//    Counters then restart.
//  - FSM MEASURE on a non-rise cycle with cnt==MAX_DIV: go to TIMEOUT.
//    o_timeout<=1, o_locked<=0, match<=0. Counters hold; o_period/o_high hold.
//  - FSM TIMEOUT: on a rise, o_timeout<=0, load counters and go to MEASURE.
//    No o_valid on this rise, same as IDLE.
//  - A period of exactly MAX_DIV is valid. MAX_DIV+1 times out.
//  - A stuck-high or stuck-low input always ends in TIMEOUT.
//  - Lock (updated in the same cycle as o_valid, registered):
//    first valid after IDLE/TIMEOUT sets match=1.
//    cnt==o_period (previous) => match=min(match+1, LOCK_CNT).
//    Otherwise match=1 and o_locked=0.
//    o_locked = (match==LOCK_CNT); it stays up while periods stay equal.
//  - Minimum period 2 (toggle every i_clk) measures period 2, high 1.
//    Faster inputs alias and are unsupported.
//  - Reset mid-measurement: immediate return to reset state. The next o_valid
//    needs two fresh rises.
//  - o_high is informational only: a change in duty with equal period does not
//    drop lock.
// TESTING
//  1. Reset, then period 15 / high 7 waveform (i_div_clk sync to i_clk) ->
//     first o_valid at 2nd rise+3 cycles, o_period=15, o_high=7;
//     o_locked rises with the 4th o_valid.
//  2. Locked at 15, switch to period 8 / high 4 -> first valid: o_period=8,
//     o_locked=0; re-lock on the 4th valid of period 8.
//  3. Hold i_div_clk high after lock (MAX_DIV=64) -> o_timeout=1 and o_locked=0
//     exactly 64 cycles after the last rise is seen. Resume toggling ->
//     o_timeout clears on the first rise, no valid until the second.
//  4. Boundary: period 64 -> o_valid with o_period=64, o_timeout stays 0;
//     period 65 -> o_timeout, no o_valid.
//  5. Period 2 (toggle each i_clk) -> o_period=2, o_high=1, o_locked after 4 valids.
//  6. Pulse i_rst_n low mid-period while locked -> all outputs 0 asynchronously;
//     after release, valid only on the 2nd rise, lock re-acquired after LOCK_CNT.

Source files
------------

// File: rtl/clk_ratio_meter.sv
// Measures a slow clock, sampled as data, against i_clk: period, high time,
// lock on repeated equal periods, and a stall timeout.
module clk_ratio_meter #(
  parameter int  MAX_DIV  = 64,
  parameter int  LOCK_CNT = 4,
  localparam int CW       = $clog2(MAX_DIV + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_div_clk,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_high,
  output logic          o_valid,
  output logic          o_locked,
  output logic          o_timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

  state_t        state_q, state_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CW-1:0] cnt_q, cnt_d, hi_q, hi_d;
  logic [CW-1:0] period_q, period_d, high_q, high_d;
  logic          valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
  logic [MW-1:0] match_q, match_d;
  logic          rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    s1_d      = i_div_clk;
    s2_d      = s1_q;
    s3_d      = s2_q;
    rise      = s2_q & ~s3_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    match_d   = match_q;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = CW'(1);
          hi_d    = CW'(1);
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (rise) begin
          cnt_d    = CW'(1);
          hi_d     = CW'(1);
          period_d = cnt_q;
          high_d   = hi_q;
          valid_d  = 1'b1;
          // match==0 marks the first period after IDLE or TIMEOUT
          if (match_q == '0) begin
            match_d = MW'(1);
          end else if (cnt_q == period_q) begin
            match_d = (match_q == MW'(LOCK_CNT)) ? match_q : match_q + MW'(1);
          end else begin
            match_d = MW'(1);
          end
          locked_d = (match_d == MW'(LOCK_CNT));
        end else if (cnt_q == CW'(MAX_DIV)) begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          hi_d  = hi_q + CW'(s2_q);
        end
      end

      TIMEOUT: begin
        if (rise) begin
          timeout_d = 1'b0;
          cnt_d     = CW'(1);
          hi_d      = CW'(1);
          state_d   = MEASURE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_valid   = valid_q;
  assign o_locked  = locked_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: every rise driven on i_div_clk queues
// the valid/timeout events it should cause, and a monitor matches DUT outputs.
module tb_clk_ratio_meter;

  localparam int MAX_DIV  = 64;
  localparam int LOCK_CNT = 4;
  localparam int CW       = $clog2(MAX_DIV + 1);

  logic          clk;
  logic          i_rst_n;
  logic          i_div_clk;
  logic [CW-1:0] o_period;
  logic [CW-1:0] o_high;
  logic          o_valid;
  logic          o_locked;
  logic          o_timeout;

  typedef struct {
    int cyc;
    int period;
    int high;
    int locked;
  } exp_t;

  exp_t validQ[$];
  int   tmoQ[$];
  int   clrQ[$];

  int testsRun = 0;
  int failCnt  = 0;
  int cyc      = 0;

  // Reference model state, kept in terms of periods driven
  bit armed    = 0;
  bit timedOut = 0;
  int prevP    = 0;
  int prevH    = 0;
  int mCnt     = 0;
  int lastP    = 0;
  logic prevTo = 0;

  clk_ratio_meter #(.MAX_DIV(MAX_DIV), .LOCK_CNT(LOCK_CNT)) dut (
    .i_clk    (clk),
    .i_rst_n  (i_rst_n),
    .i_div_clk(i_div_clk),
    .o_period (o_period),
    .o_high   (o_high),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic resetModel();
    armed    = 0;
    timedOut = 0;
    mCnt     = 0;
    lastP    = 0;
    validQ.delete();
    tmoQ.delete();
    clrQ.delete();
  endtask

  // Called at the negedge where a new period p/h begins with a rising edge
  task automatic noteRise(input int p, input int h);
    exp_t e;
    if (armed) begin
      if (mCnt == 0)          mCnt = 1;
      else if (prevP == lastP) mCnt = (mCnt < LOCK_CNT) ? mCnt + 1 : LOCK_CNT;
      else                    mCnt = 1;
      lastP    = prevP;
      e.cyc    = cyc + 3;
      e.period = prevP;
      e.high   = prevH;
      e.locked = (mCnt == LOCK_CNT) ? 1 : 0;
      validQ.push_back(e);
    end else begin
      if (timedOut) begin
        clrQ.push_back(cyc + 3);
        timedOut = 0;
      end
      armed = 1;
    end
    prevP = p;
    prevH = h;
    if (p > MAX_DIV) begin
      tmoQ.push_back(cyc + 3 + MAX_DIV);
      armed    = 0;
      mCnt     = 0;
      timedOut = 1;
    end
  endtask

  // Drive the first n cycles of a period p with high time h
  task automatic applyStimulus(input int p, input int h, input int n = -1);
    int lim;
    lim = (n < 0) ? p : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (i == 0) noteRise(p, h);
      i_div_clk = (i < h);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_period"},  32'(o_period),  0);
    checkOutput({tag, "_high"},    32'(o_high),    0);
    checkOutput({tag, "_valid"},   32'(o_valid),   0);
    checkOutput({tag, "_locked"},  32'(o_locked),  0);
    checkOutput({tag, "_timeout"}, 32'(o_timeout), 0);
  endtask

  // Monitor: pop expected events as the DUT produces them
  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (!i_rst_n) begin
      prevTo <= 1'b0;
    end else begin
      if (o_valid) begin
        checkOutput("valid_expected", 32'(validQ.size() > 0), 1);
        if (validQ.size() > 0) begin
          e = validQ.pop_front();
          checkOutput("valid_cycle", cyc, e.cyc);
          checkOutput("period", 32'(o_period), e.period);
          checkOutput("high", 32'(o_high), e.high);
          checkOutput("locked", 32'(o_locked), e.locked);
        end
      end
      if (o_timeout && !prevTo) begin
        checkOutput("timeout_expected", 32'(tmoQ.size() > 0), 1);
        if (tmoQ.size() > 0) begin
          t = tmoQ.pop_front();
          checkOutput("timeout_cycle", cyc, t);
          checkOutput("locked_at_timeout", 32'(o_locked), 0);
        end
      end else if (!o_timeout && prevTo) begin
        checkOutput("clear_expected", 32'(clrQ.size() > 0), 1);
        if (clrQ.size() > 0) begin
          t = clrQ.pop_front();
          checkOutput("timeout_clear_cycle", cyc, t);
        end
      end
      prevTo <= o_timeout;
    end
  end

  initial begin
    i_rst_n   = 1'b0;
    i_div_clk = 1'b0;
    resetModel();
    repeat (3) @(negedge clk);
    checkResetState("reset");
    i_rst_n = 1'b1;

    $display("[TB] step 1: period 15 high 7, lock on 4th valid");
    repeat (5) applyStimulus(15, 7);

    $display("[TB] step 2: switch to period 8 high 4, relock");
    repeat (5) applyStimulus(8, 4);

    $display("[TB] step 3: stuck high, timeout, resume");
    applyStimulus(120, 119);
    repeat (6) applyStimulus(10, 5);

    $display("[TB] step 4: period 64 valid, period 65 times out");
    applyStimulus(64, 32);
    applyStimulus(64, 10);
    applyStimulus(65, 30);
    repeat (3) applyStimulus(6, 3);

    $display("[TB] step 5: period 2");
    repeat (6) applyStimulus(2, 1);

    $display("[TB] step 6: reset mid-period while locked");
    repeat (6) applyStimulus(12, 6);
    checkOutput("locked_before_reset", 32'(o_locked), 1);
    applyStimulus(12, 6, 5);
    @(negedge clk);
    #2;
    i_rst_n   = 1'b0;
    i_div_clk = 1'b0;
    #1;
    checkResetState("async_reset");
    resetModel();
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (6) applyStimulus(12, 6);

    @(negedge clk);
    i_div_clk = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("pending_valids", validQ.size(), 0);
    checkOutput("pending_timeouts", tmoQ.size(), 0);
    checkOutput("pending_clears", clrQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
